// File: rtl/stepdir_seq.sv
// Step/dir sequencer for one stepper axis: queued moves, ramped
// intervals, dwell, dir setup guard, pulse shaping and position.
module stepdir_seq #(
  parameter int MOVE_TYPE_BITS     = 3,
  parameter int STEP_INTERVAL_BITS = 22,
  parameter int STEP_COUNT_BITS    = 26,
  parameter int STEP_ADD_BITS      = 20,
  parameter int MOVE_COUNT         = 512,
  parameter int STEP_PULSE         = 4,
  parameter int DIR_SETUP          = 8,
  parameter int QW = MOVE_TYPE_BITS + 1 + STEP_INTERVAL_BITS
                   + STEP_COUNT_BITS + STEP_ADD_BITS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [QW-1:0] queue_wr_data,
  input  logic          queue_wr_en,
  output logic          queue_empty,
  output logic          queue_full,
  input  logic          start,
  input  logic          stop,
  input  logic          dedge,
  input  logic          pos_load,
  input  logic [31:0]   pos_value,
  output logic          running,
  output logic          step,
  output logic          dir,
  output logic [31:0]   position,
  output logic          error
);

  localparam int TW  = MOVE_TYPE_BITS;
  localparam int IW  = STEP_INTERVAL_BITS;
  localparam int CW  = STEP_COUNT_BITS;
  localparam int AW  = STEP_ADD_BITS;
  localparam int PW  = $clog2(MOVE_COUNT);
  localparam int SW  = IW + 1;
  localparam int XW  = IW + 3;
  localparam int PCW = $clog2(STEP_PULSE + 1);
  localparam int DW  = $clog2(DIR_SETUP + 2);

  localparam logic [TW-1:0] T_STEP  = '0;
  localparam logic [TW-1:0] T_DWELL = TW'(1);
  localparam logic signed [XW-1:0] ONE = XW'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  // move queue
  logic [QW-1:0] mem_q [MOVE_COUNT];
  logic [PW:0]   wptr_q, wptr_d;
  logic [PW:0]   rptr_q, rptr_d;
  logic          push, pop;
  logic [QW-1:0] head;

  assign queue_empty = (wptr_q == rptr_q);
  assign queue_full  = (wptr_q[PW] != rptr_q[PW])
                    && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign push = queue_wr_en & ~queue_full;
  assign head = mem_q[rptr_q[PW-1:0]];

  always_comb begin
    wptr_d = wptr_q + (PW+1)'(push);
    rptr_d = rptr_q + (PW+1)'(pop);
    if (stop) begin
      wptr_d = '0;
      rptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[PW-1:0]] <= queue_wr_data;
  end

  logic [TW-1:0] h_type;
  logic          h_dir;
  logic [IW-1:0] h_int;
  logic [CW-1:0] h_cnt;
  logic [AW-1:0] h_add;

  assign h_type = head[QW-1 -: TW];
  assign h_dir  = head[IW+CW+AW];
  assign h_int  = head[CW+AW +: IW];
  assign h_cnt  = head[AW +: CW];
  assign h_add  = head[AW-1:0];

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  tmr_q, tmr_d;
  logic [IW-1:0]  int_q, int_d;
  logic [AW-1:0]  add_q, add_d;
  logic           dwell_q, dwell_d;
  logic [SW-1:0]  since_q, since_d;
  logic [DW-1:0]  dsince_q, dsince_d;
  logic           dir_q, dir_d;
  logic           step_q, step_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [31:0]    pos_q, pos_d;
  logic           err_q, err_d;

  assign running  = (state_q == S_RUN);
  assign step     = step_q;
  assign dir      = dir_q;
  assign position = pos_q;
  assign error    = err_q;

  logic load;
  assign load = (start | running) & ~queue_empty
              & (cnt_q == '0) & ~stop;

  logic [IW-1:0] min_i, ld_eff, st_eff;
  logic [IW-1:0] add_x, nxt_int;
  logic [IW-1:0] ld_tmr, st_tmr;
  logic [SW-1:0] since_v;
  logic signed [XW-1:0] a_v, d_v, t_v;

  assign min_i   = dedge ? IW'(2) : IW'(STEP_PULSE + 1);
  assign add_x   = IW'($signed(add_q));
  assign nxt_int = int_q + add_x;
  assign ld_eff  = (h_int > min_i) ? h_int : min_i;
  assign st_eff  = (nxt_int > min_i) ? nxt_int : min_i;
  assign st_tmr  = st_eff - IW'(1);
  assign since_v = running ? since_q : '0;

  // first edge = max(ref + eff, dir change + setup, load + 1)
  always_comb begin
    a_v = XW'(ld_eff) - XW'(since_v);
    if (h_type != T_STEP) d_v = '0;
    else if (h_dir != dir_q) d_v = XW'(DIR_SETUP);
    else d_v = XW'(DIR_SETUP) - XW'(dsince_q);
    t_v = a_v;
    if (d_v > t_v) t_v = d_v;
    if (t_v < ONE) t_v = ONE;
    ld_tmr = IW'(t_v - ONE);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    int_d    = int_q;
    add_d    = add_q;
    dwell_d  = dwell_q;
    since_d  = since_q;
    dsince_d = dsince_q;
    dir_d    = dir_q;
    step_d   = step_q;
    pcnt_d   = pcnt_q;
    pos_d    = pos_q;
    err_d    = err_q;
    pop      = 1'b0;

    if (since_q != '1) since_d = since_q + SW'(1);
    if (dsince_q != DW'(DIR_SETUP)) dsince_d = dsince_q + DW'(1);

    if (pcnt_q != '0) pcnt_d = pcnt_q - PCW'(1);
    else if (!dedge) step_d = 1'b0;

    unique case (state_q)
      S_IDLE: if (load) state_d = S_RUN;
      S_RUN:  if (cnt_q == '0 && !load) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      pop     = 1'b1;
      dwell_d = (h_type == T_DWELL);
      int_d   = h_int;
      add_d   = h_add;
      if (!running) since_d = SW'(1);
      if (h_type > T_DWELL) begin
        err_d = 1'b1;
      end else begin
        cnt_d = h_cnt;
        tmr_d = ld_tmr;
        if (h_type == T_STEP && h_dir != dir_q) begin
          dir_d    = h_dir;
          dsince_d = DW'(1);
        end
      end
    end else if (running && cnt_q != '0) begin
      if (tmr_q == '0) begin
        cnt_d   = cnt_q - CW'(1);
        int_d   = nxt_int;
        tmr_d   = st_tmr;
        since_d = SW'(1);
        if (!dwell_q) begin
          if (dedge) begin
            step_d = ~step_q;
            pcnt_d = '0;
          end else begin
            step_d = 1'b1;
            pcnt_d = PCW'(STEP_PULSE - 1);
          end
          pos_d = dir_q ? pos_q + 32'd1 : pos_q - 32'd1;
        end
      end else begin
        tmr_d = tmr_q - IW'(1);
      end
    end

    if (pos_load) pos_d = pos_value;

    // abort leaves the pulse shaper alone so a live pulse completes
    if (stop) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tmr_q    <= '0;
      int_q    <= '0;
      add_q    <= '0;
      dwell_q  <= 1'b0;
      since_q  <= '0;
      dsince_q <= DW'(DIR_SETUP);
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      pcnt_q   <= '0;
      pos_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmr_q    <= tmr_d;
      int_q    <= int_d;
      add_q    <= add_d;
      dwell_q  <= dwell_d;
      since_q  <= since_d;
      dsince_q <= dsince_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      pcnt_q   <= pcnt_d;
      pos_q    <= pos_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_stepdir_seq.sv
// Bench for stepdir_seq: event-schedule reference model, random
// and directed move batches, queue fill, stop and reset cases.
module tb_stepdir_seq;

  localparam int SP = 4;
  localparam int DS = 8;
  localparam int QW = 72;
  localparam longint IMASK = (64'd1 << 22) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [QW-1:0] queue_wr_data = '0;
  logic          queue_wr_en = 1'b0;
  logic          queue_empty, queue_full;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          dedge = 1'b0;
  logic          pos_load = 1'b0;
  logic [31:0]   pos_value = '0;
  logic          running, step, dir, error;
  logic [31:0]   position;

  stepdir_seq dut (
    .clk(clk), .reset(reset),
    .queue_wr_data(queue_wr_data), .queue_wr_en(queue_wr_en),
    .queue_empty(queue_empty), .queue_full(queue_full),
    .start(start), .stop(stop), .dedge(dedge),
    .pos_load(pos_load), .pos_value(pos_value),
    .running(running), .step(step), .dir(dir),
    .position(position), .error(error)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  typedef struct {
    int typ;
    int dr;
    int iv;
    int cnt;
    int add;
  } mv_t;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  mv_t    mq[$];
  longint st_t[$];
  int     st_d[$];
  longint dc_t[$];
  int     dc_v[$];
  int     m_dir = 0;
  int     m_pos = 0;
  bit     m_err = 0;
  longint m_lastdc = -1000;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d expected %0d",
               tag, cyc, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  function automatic longint eff(input longint i, input bit de);
    longint mn;
    mn = de ? 2 : SP + 1;
    return (i < mn) ? mn : i;
  endfunction

  task automatic push_raw(input mv_t m);
    logic [2:0]  t;
    logic        d;
    logic [21:0] iv;
    logic [25:0] c;
    logic [19:0] a;
    t  = m.typ[2:0];
    d  = m.dr[0];
    iv = m.iv[21:0];
    c  = m.cnt[25:0];
    a  = m.add[19:0];
    queue_wr_data = {t, d, iv, c, a};
    queue_wr_en = 1'b1;
    tick();
    queue_wr_en = 1'b0;
  endtask

  task automatic push(input mv_t m);
    push_raw(m);
    mq.push_back(m);
  endtask

  // start the queued moves and compare every cycle to the schedule
  task automatic run_batch(input bit de, input int pl_j,
                           input int pl_val);
    longint t0, ld, rf, s, last, end_t, pl_t, err_t, i, n;
    int dir0, pos0, e_pos, e_dir, ns;
    bit err0, e_step;
    dedge = de;
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    st_t.delete(); st_d.delete(); dc_t.delete(); dc_v.delete();
    dir0 = m_dir; pos0 = m_pos; err0 = m_err; err_t = -1;
    ld = t0; rf = t0; last = t0; e_pos = pos0;
    foreach (mq[k]) begin
      last = ld;
      if (mq[k].typ >= 2) begin
        if (err_t < 0) err_t = ld;
        ld++;
        continue;
      end
      if (mq[k].typ == 0 && mq[k].dr != m_dir) begin
        m_dir = mq[k].dr;
        m_lastdc = ld;
        dc_t.push_back(ld);
        dc_v.push_back(m_dir);
      end
      if (mq[k].cnt == 0) begin
        ld++;
        continue;
      end
      i = mq[k].iv;
      s = rf + eff(i, de);
      if (s < ld + 1) s = ld + 1;
      if (mq[k].typ == 0 && s < m_lastdc + DS) s = m_lastdc + DS;
      for (int j = 0; j < mq[k].cnt; j++) begin
        if (j > 0) begin
          i = (i + mq[k].add) & IMASK;
          s += eff(i, de);
        end
        if (mq[k].typ == 0) begin
          st_t.push_back(s);
          st_d.push_back(mq[k].dr != 0 ? 1 : -1);
        end
        rf = s;
      end
      last = s;
      ld = s + 1;
    end
    end_t = last;
    mq.delete();
    pl_t = (pl_j >= 0 && pl_j < st_t.size()) ? st_t[pl_j] : -1;
    while (cyc <= end_t + 4) begin
      n = cyc;
      e_step = 1'b0; ns = 0; e_dir = dir0;
      e_pos = (pl_t >= 0 && n >= pl_t) ? pl_val : pos0;
      foreach (st_t[j]) begin
        if (st_t[j] <= n) begin
          ns++;
          if (!(pl_t >= 0 && n >= pl_t && st_t[j] <= pl_t))
            e_pos += st_d[j];
        end
        if (!de && st_t[j] <= n && n < st_t[j] + SP) e_step = 1'b1;
      end
      if (de) e_step = ns[0];
      foreach (dc_t[j]) if (dc_t[j] <= n) e_dir = dc_v[j];
      chk("step", step, e_step);
      chk("dir", dir, e_dir);
      chk("pos", $signed(position), e_pos);
      chk("run", running, (n >= t0 && n <= end_t) ? 1 : 0);
      chk("err", error, (err0 || (err_t >= 0 && n >= err_t)) ? 1 : 0);
      pos_load = (pl_t >= 0 && n + 1 == pl_t);
      pos_value = pl_val;
      tick();
    end
    pos_load = 1'b0;
    m_pos = e_pos;
    if (err_t >= 0) m_err = 1'b1;
  endtask

  task automatic gap();
    dedge = 1'b0;
    repeat (12) tick();
    chk("gap_step", step, 0);
  endtask

  initial begin
    longint t0;
    int nd;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    chk("rst_step", step, 0);
    chk("rst_dir", dir, 0);
    chk("rst_run", running, 0);
    chk("rst_pos", position, 0);
    chk("rst_err", error, 0);
    chk("rst_empty", queue_empty, 1);

    push('{0, 1, 100, 3, 0});
    run_batch(1'b0, -1, 0);
    chk("t1_pos", position, 3);
    gap();

    push('{0, 1, 50, 4, -10});
    push('{0, 1, 5, 2, -3});
    run_batch(1'b0, -1, 0);
    gap();

    push('{0, 1, 20, 2, 0});
    push('{0, 0, 3, 1, 0});
    run_batch(1'b0, -1, 0);
    chk("t3_pos", position, 10);
    gap();

    push('{0, 1, 10, 1, 0});
    push('{1, 0, 30, 2, 0});
    push('{0, 1, 10, 1, 0});
    push('{5, 0, 10, 3, 0});
    push('{0, 1, 10, 1, 0});
    run_batch(1'b0, -1, 0);
    chk("t4_pos", position, 13);
    chk("t4_err", error, 1);
    gap();

    push('{0, 0, 10, 4, 0});
    run_batch(1'b1, 3, 1000);
    chk("t5_pos", position, 1000);
    chk("t5_step", step, 0);
    gap();

    repeat (25) begin
      nd = $urandom_range(1, 5);
      for (int k = 0; k < nd; k++) begin
        mv_t m;
        int r;
        r = $urandom_range(0, 9);
        m.typ = (r < 6) ? 0 : (r < 8) ? 1 : int'($urandom_range(2, 7));
        m.dr  = $urandom_range(0, 1);
        m.iv  = $urandom_range(0, 40);
        m.cnt = $urandom_range(0, 4);
        m.add = int'($urandom_range(0, 12)) - 6;
        if (m.iv + (m.cnt - 1) * m.add < 0) m.add = 0;
        push(m);
      end
      run_batch($urandom_range(0, 1),
                ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1,
                int'($urandom));
      gap();
    end

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int k = 0; k < 512; k++) push_raw('{0, 0, 10, 0, 0});
    chk("fill_full", queue_full, 1);
    chk("fill_empty", queue_empty, 0);
    push_raw('{0, 1, 10, 1, 0});
    chk("fill_full2", queue_full, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    nd = 0;
    while (running && nd < 2000) begin
      nd++;
      tick();
    end
    chk("drain_cyc", nd, 512);
    chk("drain_empty", queue_empty, 1);
    chk("drop_pos", position, 0);
    chk("drop_dir", dir, 0);

    push_raw('{0, 1, 20, 10, 0});
    push_raw('{0, 1, 20, 10, 0});
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 41) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_run", running, 0);
    chk("stop_empty", queue_empty, 1);
    chk("stop_pulse", step, 1);
    repeat (3) tick();
    chk("stop_fall", step, 0);
    repeat (100) tick();
    chk("stop_pos", position, 2);
    chk("stop_idle", running, 0);

    push_raw('{0, 1, 20, 3, 0});
    start = 1'b1;
    tick();
    start = 1'b0;
    t0 = cyc;
    while (cyc < t0 + 21) tick();
    chk("pre_rst_step", step, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_step", step, 0);
    chk("mid_rst_pos", position, 0);
    chk("mid_rst_run", running, 0);
    chk("mid_rst_empty", queue_empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
